fifo_wr_arbiter: RTL

Round-robin arbiter that shares the single write port of `async_fifo` among `N_REQ` write-side requesters, all in the `wclk` domain. Grants are burst-locked: a winner keeps the port for up to `MAX_BURST` beats or until it drops valid, then the next requester is chosen. The block drives `wdata`/`winc` and obeys `wfull` directly, so the FIFO never sees a write while full.

---
 rtl/fifo_wr_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the async_fifo write port; FIFO_WR_ARB_PRIO_EN makes requester 0 strict-priority.
// Latency: one arbitration cycle from req_valid to first beat, one bubble cycle between bursts.
// Backpressure: wfull stalls the owner combinationally (req_ready/winc low) while the grant is held.
module fifo_wr_arbiter #(
  parameter type data_t    = logic [7:0],
  parameter int  N_REQ     = 4,
  parameter int  MAX_BURST = 4
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic [N_REQ-1:0]        req_valid,
  input  data_t [N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        gnt,
  output data_t                   wdata,
  output logic                    winc,
  input  logic                    wfull
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    pick;
  logic [CW-1:0]    beat_cnt;
  logic [N_REQ-1:0] rot;
  logic [IW:0]      pick_sum;
  logic             own_vld;
  logic             beat;
  logic             last_beat;

  // rot[k] is requester (rr_ptr + k) mod N_REQ; the lowest set bit wins.
  always_comb begin
    rot      = N_REQ'({req_valid, req_valid} >> rr_ptr);
    pick_sum = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pick_sum = {1'b0, rr_ptr} + (IW+1)'(i);
    end
    pick = (pick_sum >= (IW+1)'(N_REQ)) ? IW'(pick_sum - (IW+1)'(N_REQ)) : IW'(pick_sum);
`ifdef FIFO_WR_ARB_PRIO_EN
    if (req_valid[0]) pick = '0;
`endif
  end

  assign own_vld   = req_valid[owner];
  assign beat      = (state == BURST) && own_vld && !wfull;
  assign last_beat = beat && (beat_cnt == CW'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    if (state == BURST) begin
      req_ready[owner] = !wfull;
      winc             = beat;
      wdata            = req_data[owner];
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      gnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state     <= BURST;
            owner     <= pick;
            beat_cnt  <= '0;
            gnt       <= '0;
            gnt[pick] <= 1'b1;
          end
        end
        BURST: begin
          // An abandoned burst and a full burst both hand priority to the next index.
          if (!own_vld || last_beat) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
          end
          if (beat) beat_cnt <= beat_cnt + CW'(1);
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end
endmodule
